// File: rtl/vga_timing_pipe.sv
// ---------------------------------------------------------------------------
// vga_timing_pipe
//
// VGA raster timing generator with a fetch-ahead coordinate interface.
// CURX/CURY tell an upstream frame source which pixel to produce. That pixel
// comes back on COLOR_DATA_IN and appears on RED/GREEN/BLUE exactly LEAD
// cycles after its coordinate was presented. HS/VS/BLANK go through a
// LEAD-stage delay line so they stay aligned with the colour outputs.
//
// Ports
//   CLK_25MHz      in   pixel clock, rising-edge active
//   RST_N          in   asynchronous active-low reset
//   COLOR_DATA_IN  in   RGB332 pixel for the coordinate issued LEAD cycles
//                       before it shows on RED/GREEN/BLUE
//   CURX / CURY    out  coordinate to fetch (0 outside the visible area)
//   HBLANK/VBLANK  out  blanking flags aligned with CURX/CURY
//   FRAME_START    out  one-cycle pulse when coordinate (0,0) is presented
//   HS / VS        out  active-low syncs aligned with the colour outputs
//   BLANK          out  colour-output blanking flag
//   RED/GREEN/BLUE out  registered pixel colour
// ---------------------------------------------------------------------------
module vga_timing_pipe #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int LEAD   = 1
) (
  input  logic       CLK_25MHz,
  input  logic       RST_N,
  input  logic [7:0] COLOR_DATA_IN,
  output logic [9:0] CURX,
  output logic [8:0] CURY,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       FRAME_START,
  output logic       HS,
  output logic       VS,
  output logic       BLANK,
  output logic [2:0] RED,
  output logic [2:0] GREEN,
  output logic [1:0] BLUE
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] H_LAST_C = 10'(H_TOT - 1);
  localparam logic [9:0] HS_BEG_C = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END_C = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] V_LAST_C = 10'(V_TOT - 1);
  localparam logic [9:0] VS_BEG_C = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END_C = 10'(V_VIS + V_FP + V_SYNC);

  // hcnt_q/vcnt_q hold the coordinate that the next edge will present.
  // Every coordinate-aligned output is registered from them, so the first
  // edge after reset presents (0,0) together with FRAME_START.
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;

  logic [9:0] curx_q, curx_d;
  logic [8:0] cury_q, cury_d;
  logic       hblank_q, hblank_d;
  logic       vblank_q, vblank_d;
  logic       frame_start_q, frame_start_d;

  // Raw sync/blank registered alongside CURX; they head the delay line.
  logic       hsync_raw_q, hsync_raw_d;
  logic       vsync_raw_q, vsync_raw_d;
  logic       blank_raw_q;

  // chain[0] is the raw value, chain[i] feeds delay stage i, and
  // chain[LEAD] is the output stage.
  logic [LEAD-1:0] hs_dly_q, vs_dly_q, bl_dly_q;
  logic [LEAD:0]   hs_chain, vs_chain, bl_chain;

  logic [7:0] rgb_q, rgb_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST_C) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST_C) ? '0 : vcnt_q + 10'd1;
    end

    curx_d        = (hcnt_q < H_VIS_C) ? hcnt_q : '0;
    cury_d        = (vcnt_q < V_VIS_C) ? vcnt_q[8:0] : '0;
    hblank_d      = (hcnt_q >= H_VIS_C);
    vblank_d      = (vcnt_q >= V_VIS_C);
    frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
    hsync_raw_d   = !((hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C));
    vsync_raw_d   = !((vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C));
  end

  assign hs_chain = {hs_dly_q, hsync_raw_q};
  assign vs_chain = {vs_dly_q, vsync_raw_q};
  assign bl_chain = {bl_dly_q, blank_raw_q};

  // The colour register is gated by the blank value that enters the output
  // stage on this same edge, so BLANK=1 always comes with black.
  assign rgb_d = bl_chain[LEAD-1] ? 8'h00 : COLOR_DATA_IN;

  always_ff @(posedge CLK_25MHz or negedge RST_N) begin
    if (!RST_N) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      curx_q        <= '0;
      cury_q        <= '0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
      // NOTE: the whole delay line resets to inactive sync and blank=1.
      // The pre-release state is then never emitted as a visible pixel
      // while the first real coordinates travel down the line.
      hsync_raw_q   <= 1'b1;
      vsync_raw_q   <= 1'b1;
      blank_raw_q   <= 1'b1;
      hs_dly_q      <= '1;
      vs_dly_q      <= '1;
      bl_dly_q      <= '1;
      rgb_q         <= '0;
    end else begin
      // NOTE: non-blocking assignments. All registers sample the pre-edge
      // values, so statement order inside this block does not matter.
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      curx_q        <= curx_d;
      cury_q        <= cury_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
      hsync_raw_q   <= hsync_raw_d;
      vsync_raw_q   <= vsync_raw_d;
      blank_raw_q   <= hblank_d | vblank_d;
      hs_dly_q      <= hs_chain[LEAD-1:0];
      vs_dly_q      <= vs_chain[LEAD-1:0];
      bl_dly_q      <= bl_chain[LEAD-1:0];
      rgb_q         <= rgb_d;
    end
  end

  assign CURX        = curx_q;
  assign CURY        = cury_q;
  assign HBLANK      = hblank_q;
  assign VBLANK      = vblank_q;
  assign FRAME_START = frame_start_q;
  assign HS          = hs_chain[LEAD];
  assign VS          = vs_chain[LEAD];
  assign BLANK       = bl_chain[LEAD];
  assign RED         = rgb_q[7:5];
  assign GREEN       = rgb_q[4:2];
  assign BLUE        = rgb_q[1:0];

endmodule

// File: tb/tb_vga_timing_pipe.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_pipe
//
// Two instances share the clock and reset:
//   [0] default 640x480 timing, LEAD=1
//   [1] shrunken 24x11 raster, LEAD=3, so that whole frames fit in a short run
//
// A bench-side raster model advances once per cycle. The model checks the
// CURX-aligned outputs directly. It pushes the expected HS/VS/BLANK/RGB for
// each coordinate into a per-instance queue, which is popped LEAD cycles
// later when the DUT presents that pixel. The model also plays the upstream
// frame source: it returns CURX[7:0] for each coordinate after LEAD-1
// cycles.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_pipe;

  typedef struct packed {
    logic [9:0] curx;
    logic [8:0] cury;
    logic       hb;
    logic       vb;
    logic       fs;
  } front_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bl;
    logic [7:0] rgb;
  } late_t;

  typedef struct {
    int hvis, hfp, hsync, hbp, vvis, vfp, vsync, vbp, lead;
  } cfg_t;

  typedef struct {
    int     cyc;
    front_t exp;
  } vec_t;

  localparam late_t LATE_RST = '{hs: 1'b1, vs: 1'b1, bl: 1'b1, rgb: 8'h00};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] color [2];

  logic [9:0] curx0, curx1;
  logic [8:0] cury0, cury1;
  logic       hb0, hb1, vb0, vb1, fs0, fs1;
  logic       hs0, hs1, vs0, vs1, bl0, bl1;
  logic [2:0] r0, r1, g0, g1;
  logic [1:0] b0, b1;

  front_t front [2];
  late_t  late  [2];

  always #20 clk = ~clk;

  vga_timing_pipe #(.LEAD(1)) u_dflt (
    .CLK_25MHz(clk), .RST_N(rst_n), .COLOR_DATA_IN(color[0]),
    .CURX(curx0), .CURY(cury0), .HBLANK(hb0), .VBLANK(vb0),
    .FRAME_START(fs0), .HS(hs0), .VS(vs0), .BLANK(bl0),
    .RED(r0), .GREEN(g0), .BLUE(b0)
  );

  vga_timing_pipe #(
    .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .LEAD(3)
  ) u_small (
    .CLK_25MHz(clk), .RST_N(rst_n), .COLOR_DATA_IN(color[1]),
    .CURX(curx1), .CURY(cury1), .HBLANK(hb1), .VBLANK(vb1),
    .FRAME_START(fs1), .HS(hs1), .VS(vs1), .BLANK(bl1),
    .RED(r1), .GREEN(g1), .BLUE(b1)
  );

  assign front[0] = {curx0, cury0, hb0, vb0, fs0};
  assign front[1] = {curx1, cury1, hb1, vb1, fs1};
  assign late[0]  = {hs0, vs0, bl0, r0, g0, b0};
  assign late[1]  = {hs1, vs1, bl1, r1, g1, b1};

  cfg_t       cfg   [2];
  int         mh    [2];
  int         mv    [2];
  int         k     [2];
  bit         run   [2];
  late_t      exp_q [2][$];
  logic [7:0] pix_q [2][$];
  int         hb_rise [2];
  int         fs_rise [2];
  int         hs_len  [2];
  int         vs_len  [2];
  logic       prev_hb [2];
  logic       prev_hs [2];
  logic       prev_vs [2];
  vec_t       tbl [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(int cyc, int x, int y, bit hb, bit vb, bit fs);
    vec_t v;
    v.cyc = cyc;
    v.exp = '{curx: 10'(x), cury: 9'(y), hb: hb, vb: vb, fs: fs};
    return v;
  endfunction

  task automatic clear_state(input int i);
    run[i] = 1'b0;
    k[i]   = -1;
    exp_q[i].delete();
    pix_q[i].delete();
    // Outputs for the first LEAD edges after release come from the reset
    // content of the delay line.
    for (int j = 0; j < cfg[i].lead; j++) exp_q[i].push_back(LATE_RST);
    hb_rise[i] = -1;
    fs_rise[i] = -1;
    hs_len[i]  = 0;
    vs_len[i]  = 0;
    prev_hb[i] = 1'b0;
    prev_hs[i] = 1'b1;
    prev_vs[i] = 1'b1;
    color[i]   = 8'hFF;
  endtask

  task automatic check_reset(input int i, input string tag);
    check($sformatf("%s_front%0d", tag, i), front[i], '0);
    check($sformatf("%s_late%0d", tag, i), late[i], LATE_RST);
  endtask

  task automatic step(input int i);
    cfg_t       c;
    int         htot, vtot;
    front_t     ef;
    late_t      el, eo;
    logic [7:0] px;
    c    = cfg[i];
    htot = c.hvis + c.hfp + c.hsync + c.hbp;
    vtot = c.vvis + c.vfp + c.vsync + c.vbp;
    if (!run[i]) begin
      mh[i] = 0; mv[i] = 0; k[i] = 0; run[i] = 1'b1;
    end else begin
      k[i]++;
      if (mh[i] == htot - 1) begin
        mh[i] = 0;
        mv[i] = (mv[i] == vtot - 1) ? 0 : mv[i] + 1;
      end else begin
        mh[i]++;
      end
    end

    ef.curx = (mh[i] < c.hvis) ? 10'(mh[i]) : 10'd0;
    ef.cury = (mv[i] < c.vvis) ? 9'(mv[i]) : 9'd0;
    ef.hb   = (mh[i] >= c.hvis);
    ef.vb   = (mv[i] >= c.vvis);
    ef.fs   = (mh[i] == 0) && (mv[i] == 0);
    check($sformatf("front%0d", i), front[i], ef);

    px     = ef.curx[7:0];
    el.hs  = !((mh[i] >= c.hvis + c.hfp) && (mh[i] < c.hvis + c.hfp + c.hsync));
    el.vs  = !((mv[i] >= c.vvis + c.vfp) && (mv[i] < c.vvis + c.vfp + c.vsync));
    el.bl  = ef.hb | ef.vb;
    el.rgb = el.bl ? 8'h00 : px;
    exp_q[i].push_back(el);
    eo = exp_q[i].pop_front();
    check($sformatf("late%0d", i), late[i], eo);

    // Edge-based measurements on the DUT outputs.
    if (front[i].hb && !prev_hb[i]) begin
      check($sformatf("hb_rise_col%0d", i), mh[i], c.hvis);
      if (hb_rise[i] >= 0) check($sformatf("hb_period%0d", i), k[i] - hb_rise[i], htot);
      hb_rise[i] = k[i];
    end
    if (front[i].fs) begin
      if (fs_rise[i] >= 0) check($sformatf("fs_period%0d", i), k[i] - fs_rise[i], htot * vtot);
      fs_rise[i] = k[i];
    end
    if (!late[i].hs) begin
      if (prev_hs[i]) check($sformatf("hs_start%0d", i), mh[i], (c.hvis + c.hfp + c.lead) % htot);
      hs_len[i]++;
    end else begin
      if (!prev_hs[i]) check($sformatf("hs_width%0d", i), hs_len[i], c.hsync);
      hs_len[i] = 0;
    end
    if (!late[i].vs) begin
      vs_len[i]++;
    end else begin
      if (!prev_vs[i]) check($sformatf("vs_width%0d", i), vs_len[i], c.vsync * htot);
      vs_len[i] = 0;
    end
    prev_hb[i] = front[i].hb;
    prev_hs[i] = late[i].hs;
    prev_vs[i] = late[i].vs;

    // Upstream source: the pixel for a coordinate is returned LEAD-1 cycles
    // after it is requested, and is held until the next rising edge.
    pix_q[i].push_back(px);
    if (pix_q[i].size() >= c.lead) color[i] = pix_q[i].pop_front();
    else color[i] = 8'hFF;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst_n) step(i);
      else check_reset(i, "rst_hold");
    end
  endtask

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    cfg[1] = '{16, 2, 3, 3, 6, 1, 2, 2, 3};

    // Landmarks of the 24x11 raster, indexed by cycles since release.
    tbl.push_back(mk(0,   0,  0, 0, 0, 1));
    tbl.push_back(mk(5,   5,  0, 0, 0, 0));
    tbl.push_back(mk(15,  15, 0, 0, 0, 0));
    tbl.push_back(mk(16,  0,  0, 1, 0, 0));
    tbl.push_back(mk(23,  0,  0, 1, 0, 0));
    tbl.push_back(mk(24,  0,  1, 0, 0, 0));
    tbl.push_back(mk(127, 7,  5, 0, 0, 0));
    tbl.push_back(mk(147, 3,  0, 0, 1, 0));
    tbl.push_back(mk(263, 0,  0, 1, 1, 0));
    tbl.push_back(mk(264, 0,  0, 0, 0, 1));
    tbl.push_back(mk(300, 12, 1, 0, 0, 0));

    for (int i = 0; i < 2; i++) clear_state(i);

    #1 rst_n = 1'b0;
    #4;
    for (int i = 0; i < 2; i++) check_reset(i, "rst_init");
    repeat (3) run_cycle();
    rst_n = 1'b1;

    foreach (tbl[t]) begin
      for (int n = 0; n < 1000 && k[1] < tbl[t].cyc; n++) run_cycle();
      check($sformatf("vec%0d", t), front[1], tbl[t].exp);
    end

    // Three default lines: colour path, HBLANK period, HS placement/width.
    for (int n = 0; n < 5000 && k[0] < 2500; n++) run_cycle();

    // Reset in the middle of a frame, with an all-ones pixel on the input.
    for (int n = 0; n < 1000 && !(mv[1] == 5 && mh[1] == 10); n++) run_cycle();
    color[0] = 8'hFF;
    color[1] = 8'hFF;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) check_reset(i, "rst_mid");
    for (int i = 0; i < 2; i++) clear_state(i);
    repeat (2) run_cycle();
    rst_n = 1'b1;
    run_cycle();
    check("fs_after_rst0", front[0].fs, 1'b1);
    check("fs_after_rst1", front[1].fs, 1'b1);

    // Frame wrap on the small raster.
    for (int n = 0; n < 1000 && !(mh[1] == 23 && mv[1] == 10); n++) run_cycle();
    check("wrap_vb_before", front[1].vb, 1'b1);
    run_cycle();
    check("wrap_curx", front[1].curx, 10'd0);
    check("wrap_cury", front[1].cury, 9'd0);
    check("wrap_vb_after", front[1].vb, 1'b0);
    check("wrap_fs", front[1].fs, 1'b1);

    repeat (300) run_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_pipe.md
VGA_TIMING_PIPE -- requirements
Module: vga_timing_pipe

Interface
REQ-001 Parameter H_VIS, default 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels; line total 800.
REQ-003 Parameters V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, in lines; frame total 525.
REQ-004 Parameter LEAD, default 1, range 1..4: cycles by which CURX/CURY lead the corresponding pixel on RED/GREEN/BLUE.
REQ-005 The clock and reset ports SHALL be as follows. The block has one clock; reset is asynchronous and active-low.
REQ-006 CLK_25MHz  in  1  pixel clock; all state changes on its rising edge.
REQ-007 RST_N  in  1  asynchronous, active-low reset.
REQ-008 COLOR_DATA_IN  in  8  RGB332 pixel for the coordinate issued LEAD cycles earlier.
REQ-009 CURX  out  10  horizontal coordinate to fetch.
REQ-010 CURY  out  9  vertical coordinate to fetch.
REQ-011 HBLANK  out  1  high outside the visible columns, aligned with CURX.
REQ-012 VBLANK  out  1  high outside the visible lines, aligned with CURY.
REQ-013 FRAME_START  out  1  one-cycle pulse when hcnt=0 and vcnt=0, aligned with CURX.
REQ-014 HS, VS  out  1 each  sync outputs, active low, aligned with the RGB outputs.
REQ-015 BLANK  out  1  high when the RGB output is not visible, aligned with the RGB outputs.
REQ-016 RED  out  3;  GREEN  out  3;  BLUE  out  2  registered pixel color.

Function
REQ-017 The horizontal counter hcnt SHALL count 0..799 and wrap to 0; it increments every cycle.
REQ-018 The vertical counter vcnt SHALL increment only in the cycle where hcnt wraps from 799 to 0; it counts 0..524 and wraps to 0 in the same cycle as hcnt when hcnt=799 and vcnt=524.
REQ-019 CURX SHALL equal hcnt when hcnt<640, else 0.
REQ-020 CURY SHALL equal vcnt when vcnt<480, else 0; the 9-bit width never truncates a counter value.
REQ-021 HBLANK SHALL be (hcnt>=640), VBLANK SHALL be (vcnt>=480), and both SHALL be registered so they are glitch-free.
REQ-022 The raw hsync SHALL be low iff hcnt is in 656..751, and the raw vsync SHALL be low iff vcnt is in 490..491.
REQ-023 The raw blank SHALL be HBLANK OR VBLANK.
REQ-024 The raw hsync, vsync and blank SHALL pass through a LEAD-stage delay line to produce HS, VS and BLANK.
REQ-025 At each rising edge, {RED,GREEN,BLUE} SHALL load {COLOR_DATA_IN[7:5], [4:2], [1:0]} when the delayed blank entering the output stage is 0, else 0.
REQ-026 Total latency from a CURX value to its color on RED/GREEN/BLUE SHALL be exactly LEAD cycles.
REQ-027 COLOR_DATA_IN SHALL be sampled only on the rising edge, so an upstream producer updating on the falling edge meets timing.
REQ-028 The rising edges of HBLANK and VBLANK SHALL occur exactly once per line and once per frame respectively; upstream per-line and per-frame logic keys on these edges.
REQ-029 Parameter values outside their stated ranges are unsupported; no runtime checking is required.

Reset
REQ-030 While RST_N=0: hcnt=0, vcnt=0, CURX=0, CURY=0, HBLANK=0, VBLANK=0, FRAME_START=0, HS=1, VS=1, BLANK=1, RED=GREEN=BLUE=0, and every delay-line stage holds sync=1, blank=1.
REQ-031 At the first rising edge after RST_N deasserts, the counters SHALL advance from 0 and FRAME_START SHALL pulse on the cycle where (hcnt,vcnt)=(0,0) is presented.
REQ-032 Reset asserted mid-frame SHALL immediately force the values in REQ-030; no partial line is completed.

Verification
REQ-033 Release reset, count 420000 cycles -> FRAME_START pulses every 420000 cycles, and HBLANK rises every 800 cycles at hcnt=640.
REQ-034 Check HS over one line -> low for exactly 96 cycles, starting LEAD+656 cycles after CURX=0; check VS -> low for exactly 1600 cycles per frame.
REQ-035 Drive COLOR_DATA_IN = CURX[7:0] -> RED/GREEN/BLUE equal the value of CURX from LEAD cycles earlier, and are 0 whenever BLANK=1.
REQ-036 Drive COLOR_DATA_IN=8'hFF and reset during vcnt=300 -> all outputs match the reset values immediately, and the next FRAME_START occurs on the first cycle after release.
REQ-037 Repeat REQ-035 with LEAD=3 -> 3-cycle alignment, and HS/VS/BLANK are shifted by the same 3 cycles.
REQ-038 At the wrap (hcnt=799, vcnt=524) -> the next cycle gives CURX=0, CURY=0, VBLANK falls, and FRAME_START=1.
